// File: rtl/ysyx_23060096_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_pkg
// Shared definitions for the register-file writeback path.
//   REG_ADDR_W / XLEN : default register address and data widths
//   WB_EXU / WB_LSU   : requester indices, also the encoding of the
//                       round-robin pointer (which requester wins a tie)
//   wb_req_t          : writeback request bundle (valid, rd, data)
// ---------------------------------------------------------------------------
package ysyx_23060096_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic WB_EXU = 1'b0;
    localparam logic WB_LSU = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_scoreboard
// Per-register busy vector used by decode to detect RAW hazards.
//   clk, rst            : clock, asynchronous active-high reset
//   iss_valid, iss_rd   : mark iss_rd busy at the next edge (rd 0 ignored)
//   wr_en, wr_addr      : register-file write in flight; clears the bit
//   chk_ra, chk_rb      : lookup addresses
//   ra_busy, rb_busy    : combinational busy lookups
// Optional (YSYX_23060096_WB_BYPASS_EN):
//   wr_data             : data being written this cycle
//   fwd_a_data/fwd_b_data : forwarded write data when a lookup hits the
//                       write in flight; the busy output then reads 0
// ---------------------------------------------------------------------------
module ysyx_23060096_scoreboard
    import ysyx_23060096_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W
`ifdef YSYX_23060096_WB_BYPASS_EN
    , parameter int DATA_WIDTH = XLEN
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
`ifdef YSYX_23060096_WB_BYPASS_EN
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] fwd_a_data,
    output logic [DATA_WIDTH-1:0] fwd_b_data,
`endif
    input  logic [ADDR_WIDTH-1:0] chk_ra,
    input  logic [ADDR_WIDTH-1:0] chk_rb,
    output logic                  ra_busy,
    output logic                  rb_busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Next busy state: a new issue beats a completing write on the same
    // register, because the issue names a newer producer.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            if (iss_valid && (iss_rd == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        // x0 is hard-wired and never has a pending producer.
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

`ifdef YSYX_23060096_WB_BYPASS_EN
    logic hit_a_s;
    logic hit_b_s;

    // Lookups with forwarding of the write currently leaving the stage.
    always_comb begin
        hit_a_s    = wr_en && (wr_addr == chk_ra) && (wr_addr != {ADDR_WIDTH{1'b0}});
        hit_b_s    = wr_en && (wr_addr == chk_rb) && (wr_addr != {ADDR_WIDTH{1'b0}});
        ra_busy    = busy_r[chk_ra] & ~hit_a_s;
        rb_busy    = busy_r[chk_rb] & ~hit_b_s;
        fwd_a_data = hit_a_s ? wr_data : {DATA_WIDTH{1'b0}};
        fwd_b_data = hit_b_s ? wr_data : {DATA_WIDTH{1'b0}};
    end
`else
    // Plain lookups; a bit stays busy through the register-file write cycle.
    always_comb begin
        ra_busy = busy_r[chk_ra];
        rb_busy = busy_r[chk_rb];
    end
`endif

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_wb_arbiter
// Round-robin arbiter sharing the register-file write port between EXU and
// LSU writeback, with a registered write stage and a RAW busy scoreboard.
//   clk, rst                        : clock, asynchronous active-high reset
//   exu_valid/exu_ready/exu_rd/exu_data : EXU writeback handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU writeback handshake
//   iss_valid, iss_rd               : decode marks a destination busy
//   chk_ra, chk_rb, ra_busy, rb_busy : decode hazard lookups (combinational)
//   rf_wen, rf_waddr, rf_wdata      : registered register-file write port
// Optional macro YSYX_23060096_WB_BYPASS_EN adds fwd_a_data/fwd_b_data.
// ---------------------------------------------------------------------------
module ysyx_23060096_rf_wb_arbiter
    import ysyx_23060096_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_ra,
    input  logic [ADDR_WIDTH-1:0] chk_rb,
    output logic                  ra_busy,
    output logic                  rb_busy,
`ifdef YSYX_23060096_WB_BYPASS_EN
    output logic [DATA_WIDTH-1:0] fwd_a_data,
    output logic [DATA_WIDTH-1:0] fwd_b_data,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    logic                  rr_ptr_r;
    logic                  exu_hs_s;
    logic                  lsu_hs_s;
    logic [ADDR_WIDTH-1:0] sel_rd_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Grant: a lone requester always wins; a tie goes to rr_ptr_r. The write
    // stage never stalls, so a grant is the handshake.
    always_comb begin
        exu_hs_s = 1'b0;
        lsu_hs_s = 1'b0;
        if (exu_valid && lsu_valid) begin
            if (rr_ptr_r == WB_LSU) begin
                lsu_hs_s = 1'b1;
            end else begin
                exu_hs_s = 1'b1;
            end
        end else if (exu_valid) begin
            exu_hs_s = 1'b1;
        end else if (lsu_valid) begin
            lsu_hs_s = 1'b1;
        end else begin
            exu_hs_s = 1'b0;
            lsu_hs_s = 1'b0;
        end
        exu_ready = exu_hs_s;
        lsu_ready = lsu_hs_s;
    end

    // Winner's payload for the write stage.
    always_comb begin
        if (lsu_hs_s) begin
            sel_rd_s   = lsu_rd;
            sel_data_s = lsu_data;
        end else begin
            sel_rd_s   = exu_rd;
            sel_data_s = exu_data;
        end
    end

    // Round-robin pointer: after any handshake, favour the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= WB_EXU;
        end else if (exu_hs_s) begin
            rr_ptr_r <= WB_LSU;
        end else if (lsu_hs_s) begin
            rr_ptr_r <= WB_EXU;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Write stage: one-cycle pulse per handshake; writes to x0 are swallowed
    // here so neither the register file nor the scoreboard sees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= {ADDR_WIDTH{1'b0}};
            rf_wdata <= {DATA_WIDTH{1'b0}};
        end else if ((exu_hs_s || lsu_hs_s) && (sel_rd_s != {ADDR_WIDTH{1'b0}})) begin
            rf_wen   <= 1'b1;
            rf_waddr <= sel_rd_s;
            rf_wdata <= sel_data_s;
        end else begin
            rf_wen   <= 1'b0;
            rf_waddr <= rf_waddr;
            rf_wdata <= rf_wdata;
        end
    end

    ysyx_23060096_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
`ifdef YSYX_23060096_WB_BYPASS_EN
        , .DATA_WIDTH (DATA_WIDTH)
`endif
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .wr_en      (rf_wen),
        .wr_addr    (rf_waddr),
`ifdef YSYX_23060096_WB_BYPASS_EN
        .wr_data    (rf_wdata),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
`endif
        .chk_ra     (chk_ra),
        .chk_rb     (chk_rb),
        .ra_busy    (ra_busy),
        .rb_busy    (rb_busy)
    );

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for ysyx_23060096_rf_wb_arbiter. Each granted
// request pushes its expected register-file write onto a queue; the entry is
// popped and compared one cycle later against rf_wen/rf_waddr/rf_wdata.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_ra;
    logic [4:0]  chk_rb;
    logic        ra_busy;
    logic        rb_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef YSYX_23060096_WB_BYPASS_EN
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
`endif

    int checks;
    int failures;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    ysyx_23060096_rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_ra     (chk_ra),
        .chk_rb     (chk_rb),
        .ra_busy    (ra_busy),
        .rb_busy    (rb_busy),
`ifdef YSYX_23060096_WB_BYPASS_EN
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
`endif
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle with the currently driven inputs: check the
    // grant, queue the write it implies, clock, then check the write stage.
    task automatic arb_cycle(input string tag, input logic e_exu, input logic e_lsu);
        exp_t e;
        exp_t got;
        #1;
        chk({tag, ".exu_ready"}, {31'd0, exu_ready}, {31'd0, e_exu});
        chk({tag, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, e_lsu});
        if (e_exu) begin
            e.wen = (exu_rd != 5'd0); e.addr = exu_rd; e.data = exu_data;
        end else if (e_lsu) begin
            e.wen = (lsu_rd != 5'd0); e.addr = lsu_rd; e.data = lsu_data;
        end else begin
            e.wen = 1'b0; e.addr = 5'd0; e.data = 32'd0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".rf_wen"}, {31'd0, rf_wen}, {31'd0, got.wen});
            if (got.wen) begin
                chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, got.addr});
                chk({tag, ".rf_wdata"}, rf_wdata, got.data);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        chk_ra    = 5'd5; chk_rb = 5'd7;

        // Reset and idle.
        tick(); tick();
        chk("rst.rf_wen", {31'd0, rf_wen}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle.rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("idle.rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("idle.rf_wdata", rf_wdata, 32'd0);
        chk("idle.ra_busy", {31'd0, ra_busy}, 32'd0);
        chk("idle.rb_busy", {31'd0, rb_busy}, 32'd0);

        // EXU alone.
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h0000_1234;
        arb_cycle("exu_alone", 1'b1, 1'b0);
        exu_valid = 1'b0;

        // LSU alone leaves the pointer on EXU.
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h0000_0088;
        arb_cycle("lsu_alone", 1'b0, 1'b1);
        lsu_valid = 1'b0;

        // Both valid for four cycles: E, L, E, L with back-to-back writes.
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAAAA_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004;
        arb_cycle("rr0", 1'b1, 1'b0);
        arb_cycle("rr1", 1'b0, 1'b1);
        arb_cycle("rr2", 1'b1, 1'b0);
        arb_cycle("rr3", 1'b0, 1'b1);
        exu_valid = 1'b0; lsu_valid = 1'b0;

        // Scoreboard set by issue, cleared by the LSU write to r7.
        chk_rb = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
        #1 chk("sb7.pre_issue", {31'd0, rb_busy}, 32'd0);
        tick();
        iss_valid = 1'b0;
        chk("sb7.after_issue", {31'd0, rb_busy}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
        arb_cycle("sb7.wr", 1'b0, 1'b1);
        lsu_valid = 1'b0;
`ifdef YSYX_23060096_WB_BYPASS_EN
        chk("sb7.wr_cycle_bypass", {31'd0, rb_busy}, 32'd0);
`else
        chk("sb7.wr_cycle", {31'd0, rb_busy}, 32'd1);
`endif
        tick();
        chk("sb7.cleared", {31'd0, rb_busy}, 32'd0);

        // Same-cycle set and clear on r9: set wins.
        chk_ra = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("sb9.busy", {31'd0, ra_busy}, 32'd1);
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0099;
        arb_cycle("sb9.wr", 1'b1, 1'b0);
        exu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("sb9.set_wins", {31'd0, ra_busy}, 32'd1);

        // rd==0 handshakes, writes nothing, but still advances the pointer.
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000_0011;
        arb_cycle("pre_rd0", 1'b0, 1'b1);
        lsu_valid = 1'b0;
        chk_rb = 5'd0;
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0000_FFFF;
        arb_cycle("rd0", 1'b1, 1'b0);
        chk("rd0.ra_busy_kept", {31'd0, ra_busy}, 32'd1);
        chk("rd0.rb_busy_x0", {31'd0, rb_busy}, 32'd0);
        exu_rd = 5'd10; exu_data = 32'h0000_0010;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h0000_0012;
        arb_cycle("rd0.ptr_lsu", 1'b0, 1'b1);
        arb_cycle("rd0.then_exu", 1'b1, 1'b0);
        exu_valid = 1'b0; lsu_valid = 1'b0;

        // Commit to a busy r6 observed through chk_ra.
        chk_ra = 5'd6; chk_rb = 5'd1; iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h0000_CAFE;
        arb_cycle("r6.wr", 1'b1, 1'b0);
        exu_valid = 1'b0;
`ifdef YSYX_23060096_WB_BYPASS_EN
        chk("r6.bypass_busy", {31'd0, ra_busy}, 32'd0);
        chk("r6.fwd_a", fwd_a_data, 32'h0000_CAFE);
        chk("r6.fwd_b", fwd_b_data, 32'd0);
`else
        chk("r6.commit_busy", {31'd0, ra_busy}, 32'd1);
`endif
        tick();
        chk("r6.cleared", {31'd0, ra_busy}, 32'd0);

        // Reset asserted while a write pulse is out.
        chk_rb = 5'd9;
        exu_valid = 1'b1; exu_rd = 5'd13; exu_data = 32'h0000_0D0D;
        arb_cycle("rstmid.wr", 1'b1, 1'b0);
        exu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid.rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rstmid.busy9", {31'd0, rb_busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst.rf_wen", {31'd0, rf_wen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_rf_wb_arbiter.md
Name: ysyx_23060096_rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: EXU (ALU result) and LSU (load data).
- Round-robin arbitration over valid/ready handshakes; drives a registered write stage into the register file.
- Keeps a per-register busy scoreboard that decode queries for RAW stalls.
- Sits between the EXU/LSU writeback paths and the register file write port (wdata/waddr/w_en).

Parameters:
- ADDR_WIDTH, 5, register address width; 2^ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- exu_valid  in  1  EXU writeback request.
- exu_ready  out  1  EXU request granted this cycle.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request granted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- iss_valid  in  1  decode issues an instruction writing iss_rd.
- iss_rd  in  ADDR_WIDTH  destination to mark busy.
- chk_ra  in  ADDR_WIDTH  decode source A lookup.
- chk_rb  in  ADDR_WIDTH  decode source B lookup.
- ra_busy  out  1  chk_ra has a pending write (combinational).
- rb_busy  out  1  chk_rb has a pending write (combinational).
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset, async and immediate: rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0, rr_ptr=0 (EXU preferred).
- Grant is combinational:
  - Only one valid: that requester is granted.
  - Both valid: rr_ptr picks the winner (0=EXU, 1=LSU).
  - rr_ptr updates on every handshake to point at the loser. Two consecutive cycles with both valid therefore alternate EXU, LSU.
- The write stage is never back-pressured, so a handshake is valid&ready.
- The loser keeps valid asserted and holds rd/data stable until granted. Dropping valid before grant is a protocol violation.
- Latency: handshake in cycle N gives rf_wen=1 in cycle N+1 with the latched rd/data.
  - rf_wen is a one-cycle pulse per handshake.
  - Back-to-back handshakes give back-to-back pulses.
- rd==0: the request handshakes normally and advances rr_ptr, but rf_wen stays 0 in N+1 and the scoreboard is not touched.
- Scoreboard: busy[2^ADDR_WIDTH].
  - Set at the clock edge when iss_valid && iss_rd!=0.
  - Cleared at the end of the cycle in which rf_wen=1 for that address (the same edge the register file writes). The cleared bit is first visible in N+2, when the register file read also returns the new value.
  - Set and clear on the same address in the same cycle: set wins, since a new producer was issued.
  - Issuing to an already-busy register is illegal; decode must stall.
  - ra_busy=busy[chk_ra], rb_busy=busy[chk_rb]; address 0 always reads 0.
- rst asserted mid-transfer: pending rf_wen is dropped, the scoreboard is cleared, and requesters must re-present after reset.

Optional Feature:
- Macro: YSYX_23060096_WB_BYPASS_EN.
- When defined:
  - Adds outputs fwd_a_data and fwd_b_data, each DATA_WIDTH.
  - In a cycle where rf_wen=1 and rf_waddr==chk_ra (or chk_rb), with rf_waddr!=0: the matching busy output reads 0 in that same cycle, and fwd_x_data=rf_wdata.
  - Otherwise fwd_x_data=0 and decode uses the register-file value.
- When undefined: no fwd ports; busy holds until N+2 as above.

Decomposition:
- Shared package ysyx_23060096_pkg holds:
  - REG_ADDR_W=5, XLEN=32.
  - Requester index constants WB_EXU=0, WB_LSU=1.
  - The writeback request bundle typedef (valid, rd, data).
- One natural sub-module: ysyx_23060096_scoreboard, holding the busy vector, set/clear priority and the two lookup ports (plus bypass compare when enabled).
- The arbiter and write stage stay in the top module.

Test Plan:
- Reset then idle → rf_wen=0, ra_busy=rb_busy=0. Assert rst mid-pulse → rf_wen drops immediately.
- EXU alone, rd=5, data=0x1234 in cycle N → exu_ready=1 in N; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in N+1.
- EXU and LSU both valid for 4 cycles (rd 3/4) → grants E,L,E,L; rf_wen pulses in 4 consecutive cycles with matching addr/data.
- iss_rd=7, then LSU writes rd=7 → rb_busy(chk_rb=7)=1 until the cycle after the rf_wen pulse, then 0.
- iss_valid rd=9 in the same cycle as rf_wen to rd=9 → busy[9] remains 1.
- EXU rd=0, data=0xFFFF → exu_ready=1, no rf_wen pulse, busy unchanged. With YSYX_23060096_WB_BYPASS_EN: rd=6 commit with chk_ra=6 → ra_busy=0 and fwd_a_data=data in the commit cycle.
